// File: rtl/module_serial_adder_pkg.sv
// rtl/module_serial_adder_pkg.sv - shared types and constants for the bit-serial adder controller
package module_serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/module_bit_full_adder.sv
// rtl/module_bit_full_adder.sv - single-bit full adder cell shared by the serial controller
module module_bit_full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

// File: rtl/module_serial_adder_ctrl.sv
// rtl/module_serial_adder_ctrl.sv - bit-serial add/sub controller, subtract enabled by SERIAL_ADDER_SUB_EN
module module_serial_adder_ctrl
    import module_serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic             fa_sum;
    logic             fa_cout;
    logic             last_bit;
    logic             accept;
    logic             eff_sub;
    logic [WIDTH-1:0] b_load;
    logic [WIDTH-1:0] res_next;

`ifdef SERIAL_ADDER_SUB_EN
    assign eff_sub = sub_i;
    assign b_load  = sub_i ? ~b_i : b_i;
`else
    logic unused_sub;
    assign unused_sub = sub_i;
    assign eff_sub    = 1'b0;
    assign b_load     = b_i;
`endif

    module_bit_full_adder u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_sum),
        .c_o (fa_cout)
    );

    assign last_bit = (cnt_q == LAST_BIT);
    assign accept   = (state_q == IDLE) && start_i;
    // Result fills from the top so bit 0 lands at the LSB after WIDTH shifts.
    assign res_next = {fa_sum, res_q[WIDTH-1:1]};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            a_q     <= a_i;
            b_q     <= b_load;
            res_q   <= '0;
            cnt_q   <= '0;
            carry_q <= eff_sub;
        end else if (state_q == RUN) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= res_next;
            carry_q <= fa_cout;
            if (last_bit) begin
                sum_q  <= res_next;
                cout_q <= fa_cout;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == RUN);
    assign done_o  = (state_q == DONE);
    assign sum_o   = sum_q;
    assign carry_o = cout_q;

endmodule
